// File: rtl/ppfifo_stream_source.sv
// ppfifo_stream_source: drains ready ping-pong FIFO blocks onto a registered
// valid/ready stream, flagging the final word of each block, and keeps
// block/word counters plus a per-block XOR checksum for host status.
module ppfifo_stream_source #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_rd_rdy,
  output logic                  o_rd_act,
  input  logic [SIZE_WIDTH-1:0] i_rd_size,
  output logic                  o_rd_stb,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_axis_valid,
  input  logic                  i_axis_ready,
  output logic [DATA_WIDTH-1:0] o_axis_data,
  output logic                  o_axis_last,
  output logic                  o_busy,
  output logic [31:0]           o_block_count,
  output logic [31:0]           o_word_count,
  output logic [DATA_WIDTH-1:0] o_checksum
);

  localparam int unsigned CNT_WIDTH = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]            state, state_n;
  logic [SIZE_WIDTH-1:0] size, size_n;
  logic [SIZE_WIDTH-1:0] rd_cnt, rd_cnt_n;
  logic [DATA_WIDTH-1:0] run_xor, run_xor_n;
  logic                  act_n;
  logic                  valid_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  last_n;
  logic                  busy_n;
  logic [CNT_WIDTH-1:0]  block_count_n;
  logic [CNT_WIDTH-1:0]  word_count_n;
  logic [DATA_WIDTH-1:0] checksum_n;
  logic                  free_c;
  logic                  accept_c;

  // Next-state, pop strobe and next values for every registered output
  always_comb begin
    state_n       = state;
    size_n        = size;
    rd_cnt_n      = rd_cnt;
    run_xor_n     = run_xor;
    act_n         = o_rd_act;
    data_n        = o_axis_data;
    last_n        = o_axis_last;
    block_count_n = o_block_count;
    word_count_n  = o_word_count;
    checksum_n    = o_checksum;
    o_rd_stb      = 1'b0;
    free_c        = !o_axis_valid || i_axis_ready;
    accept_c      = o_axis_valid && i_axis_ready;
    valid_n       = accept_c ? 1'b0 : o_axis_valid;

    case (state)
      IDLE: begin
        if (i_enable && i_rd_rdy && !o_rd_act) begin
          act_n    = 1'b1;
          size_n   = i_rd_size;
          rd_cnt_n = '0;
          state_n  = READ;
        end
      end
      READ: begin
        if (rd_cnt == size) begin
          state_n = RELEASE;
        end else if (free_c) begin
          o_rd_stb = 1'b1;
          data_n   = i_rd_data;
          valid_n  = 1'b1;
          last_n   = (rd_cnt == size - SIZE_WIDTH'(1));
          rd_cnt_n = rd_cnt + SIZE_WIDTH'(1);
        end
      end
      RELEASE: begin
        act_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        act_n   = 1'b0;
        state_n = IDLE;
      end
    endcase

    // Running XOR restarts after each last-word acceptance, i.e. where the
    // next block's deliveries begin, even if that block was activated early.
    if (accept_c) begin
      word_count_n = o_word_count + CNT_WIDTH'(1);
      if (o_axis_last) begin
        block_count_n = o_block_count + CNT_WIDTH'(1);
        checksum_n    = run_xor ^ o_axis_data;
        run_xor_n     = '0;
      end else begin
        run_xor_n = run_xor ^ o_axis_data;
      end
    end

    busy_n = (state_n != IDLE) || valid_n;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      size          <= '0;
      rd_cnt        <= '0;
      run_xor       <= '0;
      o_rd_act      <= 1'b0;
      o_axis_valid  <= 1'b0;
      o_axis_data   <= '0;
      o_axis_last   <= 1'b0;
      o_busy        <= 1'b0;
      o_block_count <= '0;
      o_word_count  <= '0;
      o_checksum    <= '0;
    end else begin
      state         <= state_n;
      size          <= size_n;
      rd_cnt        <= rd_cnt_n;
      run_xor       <= run_xor_n;
      o_rd_act      <= act_n;
      o_axis_valid  <= valid_n;
      o_axis_data   <= data_n;
      o_axis_last   <= last_n;
      o_busy        <= busy_n;
      o_block_count <= block_count_n;
      o_word_count  <= word_count_n;
      o_checksum    <= checksum_n;
    end
  end

endmodule

// File: tb/tb_ppfifo_stream_source.sv
// Testbench for ppfifo_stream_source: a behavioural PPFIFO feeds blocks,
// expected beats go into a scoreboard queue and a negedge monitor checks them.
module tb_ppfifo_stream_source;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_enable = 1'b0;
  logic          i_rd_rdy = 1'b0;
  logic          o_rd_act;
  logic [SW-1:0] i_rd_size = '0;
  logic          o_rd_stb;
  logic [DW-1:0] i_rd_data;
  logic          o_axis_valid;
  logic          i_axis_ready = 1'b1;
  logic [DW-1:0] o_axis_data;
  logic          o_axis_last;
  logic          o_busy;
  logic [31:0]   o_block_count;
  logic [31:0]   o_word_count;
  logic [DW-1:0] o_checksum;

  logic [DW-1:0] mem [64];
  logic [5:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;
  int            stb_cnt = 0;
  int            checks = 0;
  int            failures = 0;
  int            beats = 0;
  int            ready_mode = 0;
  logic [DW:0]   exp_q [$];
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;

  ppfifo_stream_source #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_rd_rdy     (i_rd_rdy),
    .o_rd_act     (o_rd_act),
    .i_rd_size    (i_rd_size),
    .o_rd_stb     (o_rd_stb),
    .i_rd_data    (i_rd_data),
    .o_axis_valid (o_axis_valid),
    .i_axis_ready (i_axis_ready),
    .o_axis_data  (o_axis_data),
    .o_axis_last  (o_axis_last),
    .o_busy       (o_busy),
    .o_block_count(o_block_count),
    .o_word_count (o_word_count),
    .o_checksum   (o_checksum)
  );

  always #5 clk = ~clk;

  // PPFIFO read side: first-word-fall-through, reset discards unread words
  assign i_rd_data = mem[rd_ptr];
  always @(posedge clk) begin
    if (!rst) rd_ptr <= wr_ptr;
    else if (o_rd_stb) begin
      rd_ptr  <= rd_ptr + 6'd1;
      stb_cnt <= stb_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream monitor: hold stability under backpressure and scoreboard pops
  always @(negedge clk) begin
    if (!rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending)
        check("hold", 64'({o_axis_valid, o_axis_last, o_axis_data}),
              64'({1'b1, hold_last, hold_data}));
      if (o_axis_valid && i_axis_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat",
                   o_axis_data, o_axis_last);
        end else begin
          check("beat", 64'({o_axis_last, o_axis_data}), 64'(exp_q.pop_front()));
        end
        beats++;
      end
      hold_pending = o_axis_valid && !i_axis_ready;
      hold_data    = o_axis_data;
      hold_last    = o_axis_last;
    end
  end

  // Sink ready pattern: 0 = always ready, 1 = toggle, other = stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_axis_ready = 1'b1;
        1:       i_axis_ready = ~i_axis_ready;
        default: i_axis_ready = 1'b0;
      endcase
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input logic last);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 6'd1;
    exp_q.push_back({last, d});
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_act(input logic lvl, input string tag);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (o_rd_act === lvl) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: o_rd_act never reached %0b", tag, lvl);
  endtask

  task automatic wait_beats(input int target, input string tag);
    for (int n = 0; n < 200; n++) begin
      if (beats >= target) return;
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL %s: beats %0d expected %0d", tag, beats, target);
  endtask

  task automatic start_block(input logic [SW-1:0] sz, input string tag);
    i_rd_size = sz;
    i_rd_rdy  = 1'b1;
    wait_act(1'b1, tag);
    i_rd_rdy  = 1'b0;
  endtask

  initial begin
    int cnt;
    int stb0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    cycles(3);
    check("rst_act", 64'(o_rd_act), 64'(0));
    check("rst_stream", 64'({o_axis_valid, o_axis_last, o_axis_data}), 64'(0));
    check("rst_busy_stb", 64'({o_busy, o_rd_stb}), 64'(0));
    check("rst_counts", {o_block_count, o_word_count}, 64'(0));
    check("rst_checksum", 64'(o_checksum), 64'(0));
    rst = 1'b1;
    cycles(1);

    // 1: size 4, ready held, latency of two clocks to first valid
    push_word(32'h11, 1'b0);
    push_word(32'h22, 1'b0);
    push_word(32'h33, 1'b0);
    push_word(32'h44, 1'b1);
    i_enable  = 1'b1;
    i_rd_size = 24'd4;
    i_rd_rdy  = 1'b1;
    cycles(1);
    check("t1_act_after_1clk", 64'({o_rd_act, o_axis_valid}), 64'(2'b10));
    i_rd_rdy = 1'b0;
    cycles(1);
    check("t1_valid_after_2clk", 64'({o_axis_valid, o_axis_data}), 64'({1'b1, 32'h11}));
    wait_act(1'b0, "t1_release");
    wait_beats(4, "t1_beats");
    cycles(2);
    check("t1_counts", {o_block_count, o_word_count}, {32'd1, 32'd4});
    check("t1_checksum", 64'(o_checksum), 64'(32'h44));

    // 2: same block, sink ready toggling
    ready_mode = 1;
    stb0 = stb_cnt;
    push_word(32'h11, 1'b0);
    push_word(32'h22, 1'b0);
    push_word(32'h33, 1'b0);
    push_word(32'h44, 1'b1);
    start_block(24'd4, "t2_act");
    wait_act(1'b0, "t2_release");
    wait_beats(8, "t2_beats");
    cycles(3);
    check("t2_stb_count", 64'(stb_cnt - stb0), 64'(4));
    check("t2_counts", {o_block_count, o_word_count}, {32'd2, 32'd8});
    check("t2_checksum", 64'(o_checksum), 64'(32'h44));
    ready_mode = 0;
    cycles(2);

    // 3: back-to-back blocks of 3 and 2, act low for exactly one cycle
    push_word(32'h01, 1'b0);
    push_word(32'h02, 1'b0);
    push_word(32'h03, 1'b1);
    i_rd_size = 24'd3;
    i_rd_rdy  = 1'b1;
    wait_act(1'b1, "t3_act_a");
    push_word(32'hA0, 1'b0);
    push_word(32'h0B, 1'b1);
    i_rd_size = 24'd2;
    wait_act(1'b0, "t3_release_a");
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (o_rd_act) break;
      cnt++;
    end
    i_rd_rdy = 1'b0;
    check("t3_act_low_cycles", 64'(cnt), 64'(1));
    wait_act(1'b0, "t3_release_b");
    wait_beats(13, "t3_beats");
    cycles(2);
    check("t3_counts", {o_block_count, o_word_count}, {32'd4, 32'd13});
    check("t3_checksum", 64'(o_checksum), 64'(32'hAB));

    // 4: zero-size block
    stb0 = stb_cnt;
    start_block(24'd0, "t4_act");
    cnt = 1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (!o_rd_act) break;
      cnt++;
    end
    check("t4_act_high_cycles", 64'(cnt), 64'(2));
    cycles(3);
    check("t4_idle", 64'({o_busy, o_rd_act, o_axis_valid}), 64'(0));
    check("t4_counts", {o_block_count, o_word_count}, {32'd4, 32'd13});
    check("t4_checksum_stb", {o_checksum, 32'(stb_cnt - stb0)}, {32'hAB, 32'd0});

    // 5: enable dropped after second word of a size-8 block
    for (int i = 0; i < 8; i++) push_word(32'(i * 3 + 1), (i == 7));
    start_block(24'd8, "t5_act");
    i_rd_rdy = 1'b1;
    wait_beats(15, "t5_two_beats");
    i_enable = 1'b0;
    wait_act(1'b0, "t5_release");
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (o_rd_act) cnt++;
    end
    check("t5_no_activate", 64'(cnt), 64'(0));
    wait_beats(21, "t5_beats");
    check("t5_counts", {o_block_count, o_word_count}, {32'd5, 32'd21});
    check("t5_checksum", 64'(o_checksum), 64'(32'h10));
    push_word(32'h55, 1'b1);
    i_rd_size = 24'd1;
    i_enable  = 1'b1;
    wait_act(1'b1, "t5_reenable_act");
    i_rd_rdy = 1'b0;
    wait_act(1'b0, "t5_reenable_release");
    wait_beats(22, "t5_reenable_beats");
    cycles(2);
    check("t5_reenable_counts", {o_block_count, o_word_count}, {32'd6, 32'd22});
    check("t5_reenable_checksum", 64'(o_checksum), 64'(32'h55));

    // 6: reset mid-block with a word stalled in the output register
    ready_mode = 2;
    cycles(1);
    push_word(32'hD0, 1'b0);
    push_word(32'hD1, 1'b0);
    push_word(32'hD2, 1'b0);
    push_word(32'hD3, 1'b1);
    start_block(24'd4, "t6_act");
    cnt = 0;
    while (!o_axis_valid && cnt < 20) begin
      cycles(1);
      cnt++;
    end
    check("t6_valid_before_rst", 64'({o_axis_valid, o_axis_data}), 64'({1'b1, 32'hD0}));
    exp_q.delete();
    rst = 1'b0;
    cycles(1);
    check("t6_rst_ctrl", 64'({o_rd_act, o_rd_stb, o_busy}), 64'(0));
    check("t6_rst_stream", 64'({o_axis_valid, o_axis_last, o_axis_data}), 64'(0));
    check("t6_rst_counts", {o_block_count, o_word_count}, 64'(0));
    check("t6_rst_checksum", 64'(o_checksum), 64'(0));
    rst        = 1'b1;
    ready_mode = 0;
    cycles(2);
    push_word(32'hC3, 1'b1);
    cnt = beats;
    start_block(24'd1, "t6_post_act");
    wait_act(1'b0, "t6_post_release");
    wait_beats(cnt + 1, "t6_post_beats");
    cycles(2);
    check("t6_post_counts", {o_block_count, o_word_count}, {32'd1, 32'd1});
    check("t6_post_checksum", 64'(o_checksum), 64'(32'hC3));

    cycles(3);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
